output_peri_v2: RTL and testbench
=================================

# output_peri_v2

Parametrised memory-mapped output peripheral driving red/green LEDs, up to eight seven-segment digits and the LCD word. It sits behind the LSU output address window and serves the core's byte-masked stores and combinational loads. Beyond plain data registers it adds atomic set/clear/toggle aliases, per-digit hex-nibble decode, and a hardware blink engine for the red LEDs.

## Interface
Parameters:
- LEDR_W, 32, red LED width (1..32)
- LEDG_W, 32, green LED width (1..32)
- NUM_HEX, 8, implemented seven-segment digits (1..8)
- DIV_W, 24, blink prescaler width (1..32)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  8  byte address within window (word aligned; addr[1:0] ignored)
- w_data  in  32  store data
- wr_en  in  1  store strobe
- bmask  in  4  byte enables, bit i = byte i
- rd_data  out  32  load data, combinational from addr
- io_hex0..io_hex7  out  7 each  segment drive, bit0 = seg a
- io_ledr  out  LEDR_W  red LEDs after blink gating
- io_ledg  out  LEDG_W  green LEDs
- io_lcd  out  32  LCD control/data word

## Operation
- Address map: 0x00 LEDR, 0x04 LEDR_SET, 0x08 LEDR_CLR, 0x0C LEDR_TGL; 0x10 LEDG, 0x14/0x18/0x1C LEDG SET/CLR/TGL; 0x20 HEX3..0; 0x24 HEX7..4; 0x28 HEX_MODE; 0x30 LCD; 0x38 BLINK_MASK; 0x3C BLINK_DIV. Other addresses: writes ignored, read 0.
- All writes are per-byte gated by bmask; unselected bytes unchanged.
- Data write: reg byte <= w_data byte. SET: reg |= w_data; CLR: reg &= ~w_data; TGL: reg ^= w_data (per enabled byte). Bits beyond LEDR_W/LEDG_W discarded.
- Alias reads (SET/CLR/TGL) return the underlying register, zero-extended.
- HEX words: byte k holds digit k segments in [6:0]; bit 7 discarded. Digits >= NUM_HEX: writes ignored, read 0, outputs tied 0.
- HEX_MODE[7:0]: bit k = 1 -> io_hexk = active-low hex7seg(reg[3:0]) (0..F); 0 -> io_hexk = reg[6:0] raw. Bits >= NUM_HEX read 0.
- Blink engine: down-counter cnt (DIV_W) and phase bit. BLINK_DIV == 0 -> disabled, phase = 1, cnt = 0. Otherwise each cycle cnt==0 -> cnt <= BLINK_DIV, phase <= ~phase; else cnt <= cnt-1. Half-period = BLINK_DIV+1 cycles.
- Any write to BLINK_DIV (any bmask bit): cnt <= new value, phase <= 1.
- io_ledr = ledr_reg & ~(BLINK_MASK & {LEDR_W{~phase}}). LEDR read returns ledr_reg (ungated).
- rd_data for narrower fields zero-extended; HEX words read {1'b0,seg} per byte.

## Timing
- Async reset: all registers 0, phase = 1, cnt = 0; hence every output 0 (io_hexk = 0 even though raw mode).
- Write effect visible on outputs and rd_data the cycle after the wr_en edge; reads have zero latency.
- Load of same address in write cycle returns old value.
- Phase toggles exactly on the cycle cnt==0 is observed; reset mid-count returns to phase 1, count 0.
- BLINK_DIV write while cnt==0 in same cycle: write wins (reload, phase 1, no toggle).

## Structure
- Package output_peri_pkg: address localparams, hex7seg lookup constant/function.
- Sub-module hex7seg (4-bit nibble -> 7-bit active-low segments), instantiated per digit via generate.
- Blink counter in its own always_ff; register file in another.

## Test plan
- Reset mid-run -> all outputs 0, rd_data at 0x00..0x3C = 0.
- Write 0x00 = 0x0000_00F0 bmask 4'b0001, then 0x04 = 0x0F, 0x08 = 0x30, 0x0C = 0x81 -> LEDR reads 0x4E.
- bmask 4'b0010 write of 0xFFFF_FFFF to 0x10 -> LEDG = 0x0000_FF00.
- 0x20 = 0x0000_000A, HEX_MODE = 0x01 -> io_hex0 = 7'b0001000; HEX_MODE = 0 -> io_hex0 = 7'h0A.
- NUM_HEX=6: write 0x24 = 0xFFFF_FFFF -> hex4/5 = 7'h7F, hex6/7 = 0, read = 0x0000_7F7F.
- LEDR=0xFF, BLINK_MASK=0x0F, BLINK_DIV=3 -> io_ledr alternates 0xFF/0xF0 every 4 cycles; BLINK_DIV=0 -> steady 0xFF.

Source files
------------

// File: rtl/output_peri_pkg.sv
// Shared definitions for output_peri_v2: register map, write ops, seven-segment lookup.
package output_peri_pkg;

   // Word addresses inside the output window
   localparam logic [7:0] AddrLedr      = 8'h00;
   localparam logic [7:0] AddrLedrSet   = 8'h04;
   localparam logic [7:0] AddrLedrClr   = 8'h08;
   localparam logic [7:0] AddrLedrTgl   = 8'h0C;
   localparam logic [7:0] AddrLedg      = 8'h10;
   localparam logic [7:0] AddrLedgSet   = 8'h14;
   localparam logic [7:0] AddrLedgClr   = 8'h18;
   localparam logic [7:0] AddrLedgTgl   = 8'h1C;
   localparam logic [7:0] AddrHexLo     = 8'h20;
   localparam logic [7:0] AddrHexHi     = 8'h24;
   localparam logic [7:0] AddrHexMode   = 8'h28;
   localparam logic [7:0] AddrLcd       = 8'h30;
   localparam logic [7:0] AddrBlinkMask = 8'h38;
   localparam logic [7:0] AddrBlinkDiv  = 8'h3C;

   // Encoding matches addr[3:2] of the LED alias groups
   typedef enum logic [1:0] {
      OpWr  = 2'd0,
      OpSet = 2'd1,
      OpClr = 2'd2,
      OpTgl = 2'd3
   } wr_op_e;

   // Active-low segments, bit0 = seg a, index = nibble value
   localparam logic [6:0] Hex7SegLut [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] hex7seg_lut(input logic [3:0] nibble);
      return Hex7SegLut[nibble];
   endfunction

   // Byte-masked read-modify-write on a 32-bit word
   function automatic logic [31:0] apply_op(input logic [31:0] cur, input logic [31:0] data,
                                            input logic [3:0] be, input wr_op_e op);
      logic [31:0] res;
      res = cur;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            unique case (op)
               OpWr:  res[8*i +: 8] = data[8*i +: 8];
               OpSet: res[8*i +: 8] = cur[8*i +: 8] | data[8*i +: 8];
               OpClr: res[8*i +: 8] = cur[8*i +: 8] & ~data[8*i +: 8];
               OpTgl: res[8*i +: 8] = cur[8*i +: 8] ^ data[8*i +: 8];
            endcase
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/hex7seg.sv
// Nibble to active-low seven-segment decoder.
module hex7seg
   import output_peri_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = hex7seg_lut(nibble);

endmodule

// File: rtl/output_peri_v2.sv
// Memory-mapped output peripheral: LEDs with set/clr/tgl aliases, hex digits, LCD word,
// and a blink engine gating the red LEDs.
module output_peri_v2
   import output_peri_pkg::*;
#(
   parameter int unsigned LEDR_W  = 32,
   parameter int unsigned LEDG_W  = 32,
   parameter int unsigned NUM_HEX = 8,
   parameter int unsigned DIV_W   = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        addr,
   input  logic [31:0]       w_data,
   input  logic              wr_en,
   input  logic [3:0]        bmask,
   output logic [31:0]       rd_data,
   output logic [6:0]        io_hex0,
   output logic [6:0]        io_hex1,
   output logic [6:0]        io_hex2,
   output logic [6:0]        io_hex3,
   output logic [6:0]        io_hex4,
   output logic [6:0]        io_hex5,
   output logic [6:0]        io_hex6,
   output logic [6:0]        io_hex7,
   output logic [LEDR_W-1:0] io_ledr,
   output logic [LEDG_W-1:0] io_ledg,
   output logic [31:0]       io_lcd
);

   localparam logic [7:0] HexMask = 8'((32'd1 << NUM_HEX) - 32'd1);

   logic [LEDR_W-1:0] ledr_q;
   logic [LEDG_W-1:0] ledg_q;
   logic [6:0]        hex_q [8];
   logic [7:0]        hex_mode_q;
   logic [31:0]       lcd_q;
   logic [LEDR_W-1:0] blink_mask_q;
   logic [DIV_W-1:0]  blink_div_q;
   logic [DIV_W-1:0]  cnt_q;
   logic              phase_q;

   logic [7:0]  word_addr;
   wr_op_e      op;
   logic [31:0] ledr_ext, ledg_ext, mask_ext, div_ext;
   logic [31:0] ledr_new, ledg_new, mask_new, div_new, lcd_new;
   logic        ledr_we, ledg_we, hex_lo_we, hex_hi_we, mode_we, lcd_we, mask_we, div_we;
   logic        unused_bits;

   assign word_addr = {addr[7:2], 2'b00};
   assign op        = wr_op_e'(addr[3:2]);

   // Zero-extend the narrow fields so reads and RMW share one 32-bit path
   always_comb begin
      ledr_ext = '0;
      ledg_ext = '0;
      mask_ext = '0;
      div_ext  = '0;
      ledr_ext[LEDR_W-1:0] = ledr_q;
      ledg_ext[LEDG_W-1:0] = ledg_q;
      mask_ext[LEDR_W-1:0] = blink_mask_q;
      div_ext[DIV_W-1:0]   = blink_div_q;
   end

   assign ledr_new = apply_op(ledr_ext, w_data, bmask, op);
   assign ledg_new = apply_op(ledg_ext, w_data, bmask, op);
   assign mask_new = apply_op(mask_ext, w_data, bmask, OpWr);
   assign div_new  = apply_op(div_ext, w_data, bmask, OpWr);
   assign lcd_new  = apply_op(lcd_q, w_data, bmask, OpWr);

   assign ledr_we   = wr_en && (word_addr[7:4] == 4'h0);
   assign ledg_we   = wr_en && (word_addr[7:4] == 4'h1);
   assign hex_lo_we = wr_en && (word_addr == AddrHexLo);
   assign hex_hi_we = wr_en && (word_addr == AddrHexHi);
   assign mode_we   = wr_en && (word_addr == AddrHexMode);
   assign lcd_we    = wr_en && (word_addr == AddrLcd);
   assign mask_we   = wr_en && (word_addr == AddrBlinkMask);
   assign div_we    = wr_en && (word_addr == AddrBlinkDiv);

   // Truncated upper bits of the RMW results are intentionally dropped
   assign unused_bits = ^{addr[1:0], ledr_new, ledg_new, mask_new, div_new};

   // Register file
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ledr_q       <= '0;
         ledg_q       <= '0;
         hex_mode_q   <= '0;
         lcd_q        <= '0;
         blink_mask_q <= '0;
         blink_div_q  <= '0;
         for (int unsigned k = 0; k < 8; k++) hex_q[k] <= '0;
      end else begin
         if (ledr_we) ledr_q <= ledr_new[LEDR_W-1:0];
         if (ledg_we) ledg_q <= ledg_new[LEDG_W-1:0];
         if (lcd_we)  lcd_q  <= lcd_new;
         if (mask_we) blink_mask_q <= mask_new[LEDR_W-1:0];
         if (div_we)  blink_div_q  <= div_new[DIV_W-1:0];
         if (mode_we && bmask[0]) hex_mode_q <= w_data[7:0] & HexMask;
         // Unimplemented digits are never written, so they stay 0
         for (int unsigned k = 0; k < 4; k++) begin
            if (hex_lo_we && bmask[k] && (k < NUM_HEX)) hex_q[k] <= w_data[8*k +: 7];
            if (hex_hi_we && bmask[k] && (k + 4 < NUM_HEX)) hex_q[k+4] <= w_data[8*k +: 7];
         end
      end
   end

   // Blink prescaler; a BLINK_DIV write takes priority over the terminal-count toggle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else if (div_we) begin
         cnt_q   <= div_new[DIV_W-1:0];
         phase_q <= 1'b1;
      end else if (blink_div_q == '0) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else if (cnt_q == '0) begin
         cnt_q   <= blink_div_q;
         phase_q <= ~phase_q;
      end else begin
         cnt_q   <= cnt_q - DIV_W'(1);
      end
   end

   // Combinational load path
   always_comb begin
      rd_data = '0;
      case (word_addr)
         AddrLedr, AddrLedrSet, AddrLedrClr, AddrLedrTgl: rd_data = ledr_ext;
         AddrLedg, AddrLedgSet, AddrLedgClr, AddrLedgTgl: rd_data = ledg_ext;
         AddrHexLo: for (int k = 0; k < 4; k++) rd_data[8*k +: 8] = {1'b0, hex_q[k]};
         AddrHexHi: for (int k = 0; k < 4; k++) rd_data[8*k +: 8] = {1'b0, hex_q[k+4]};
         AddrHexMode:   rd_data[7:0] = hex_mode_q;
         AddrLcd:       rd_data = lcd_q;
         AddrBlinkMask: rd_data = mask_ext;
         AddrBlinkDiv:  rd_data = div_ext;
         default: ;
      endcase
   end

   logic [6:0] hex_out [8];

   for (genvar k = 0; k < 8; k++) begin : g_hex
      if (k < NUM_HEX) begin : g_dig
         logic [6:0] dec;
         hex7seg u_dec (
            .nibble (hex_q[k][3:0]),
            .seg    (dec)
         );
         assign hex_out[k] = hex_mode_q[k] ? dec : hex_q[k];
      end else begin : g_off
         assign hex_out[k] = '0;
      end
   end

   assign io_hex0 = hex_out[0];
   assign io_hex1 = hex_out[1];
   assign io_hex2 = hex_out[2];
   assign io_hex3 = hex_out[3];
   assign io_hex4 = hex_out[4];
   assign io_hex5 = hex_out[5];
   assign io_hex6 = hex_out[6];
   assign io_hex7 = hex_out[7];

   assign io_ledr = ledr_q & ~(blink_mask_q & {LEDR_W{~phase_q}});
   assign io_ledg = ledg_q;
   assign io_lcd  = lcd_q;

endmodule

// File: tb/tb_output_peri_v2.sv
// Directed self-checking bench for output_peri_v2 (NUM_HEX = 6).
module tb_output_peri_v2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  addr;
   logic [31:0] w_data;
   logic        wr_en;
   logic [3:0]  bmask;
   logic [31:0] rd_data;
   logic [6:0]  io_hex0, io_hex1, io_hex2, io_hex3, io_hex4, io_hex5, io_hex6, io_hex7;
   logic [31:0] io_ledr, io_ledg, io_lcd;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam int SelRd = 0, SelLedr = 1, SelLedg = 2, SelLcd = 3, SelHex = 10;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];

   output_peri_v2 #(
      .LEDR_W  (32),
      .LEDG_W  (32),
      .NUM_HEX (6),
      .DIV_W   (24)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .addr    (addr),
      .w_data  (w_data),
      .wr_en   (wr_en),
      .bmask   (bmask),
      .rd_data (rd_data),
      .io_hex0 (io_hex0),
      .io_hex1 (io_hex1),
      .io_hex2 (io_hex2),
      .io_hex3 (io_hex3),
      .io_hex4 (io_hex4),
      .io_hex5 (io_hex5),
      .io_hex6 (io_hex6),
      .io_hex7 (io_hex7),
      .io_ledr (io_ledr),
      .io_ledg (io_ledg),
      .io_lcd  (io_lcd)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         SelRd:      return rd_data;
         SelLedr:    return io_ledr;
         SelLedg:    return io_ledg;
         SelLcd:     return io_lcd;
         SelHex + 0: return {25'b0, io_hex0};
         SelHex + 1: return {25'b0, io_hex1};
         SelHex + 2: return {25'b0, io_hex2};
         SelHex + 3: return {25'b0, io_hex3};
         SelHex + 4: return {25'b0, io_hex4};
         SelHex + 5: return {25'b0, io_hex5};
         SelHex + 6: return {25'b0, io_hex6};
         SelHex + 7: return {25'b0, io_hex7};
         default:    return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic push_exp(input string tag, input int sel, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb.push_back(e);
   endtask

   // Settle, then pop every queued expectation against the live DUT outputs
   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      #1;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sel);
         n_cmp++;
         assert (obs === e.exp)
         else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic expect_rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
      addr = a;
      push_exp(tag, SelRd, exp);
      drain();
   endtask

   task automatic expect_out(input int sel, input logic [31:0] exp, input string tag);
      push_exp(tag, sel, exp);
      drain();
   endtask

   // Called away from posedge; the write lands on the next rising edge
   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      addr   = a;
      w_data = d;
      bmask  = be;
      wr_en  = 1'b1;
      @(negedge clk);
      wr_en  = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      push_exp({tag, "_ledr"}, SelLedr, 32'h0);
      push_exp({tag, "_ledg"}, SelLedg, 32'h0);
      push_exp({tag, "_lcd"}, SelLcd, 32'h0);
      for (int k = 0; k < 8; k++) push_exp($sformatf("%s_hex%0d", tag, k), SelHex + k, 32'h0);
      drain();
      for (int a = 0; a < 16; a++) expect_rd(8'(a * 4), 32'h0, $sformatf("%s_rd%02h", tag, a * 4));
   endtask

   initial begin
      rst_n  = 1'b0;
      addr   = '0;
      w_data = '0;
      wr_en  = 1'b0;
      bmask  = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // LEDR data / set / clr / tgl
      wr(8'h00, 32'h0000_00F0, 4'b0001);
      expect_rd(8'h00, 32'h0000_00F0, "ledr_wr");
      wr(8'h04, 32'h0000_000F, 4'b1111);
      expect_rd(8'h00, 32'h0000_00FF, "ledr_set");
      wr(8'h08, 32'h0000_0030, 4'b1111);
      expect_rd(8'h00, 32'h0000_00CF, "ledr_clr");
      wr(8'h0C, 32'h0000_0081, 4'b1111);
      expect_rd(8'h00, 32'h0000_004E, "ledr_tgl");
      expect_rd(8'h04, 32'h0000_004E, "ledr_alias_set_rd");
      expect_rd(8'h0E, 32'h0000_004E, "ledr_alias_tgl_rd_lowbits");
      expect_out(SelLedr, 32'h0000_004E, "io_ledr_plain");

      // LEDG byte-masked write
      wr(8'h10, 32'hFFFF_FFFF, 4'b0010);
      expect_rd(8'h10, 32'h0000_FF00, "ledg_bmask");
      expect_out(SelLedg, 32'h0000_FF00, "io_ledg");
      wr(8'h18, 32'h0000_0F00, 4'b0010);
      expect_rd(8'h1C, 32'h0000_F000, "ledg_clr");

      // Hex digits and decode mode
      wr(8'h20, 32'h0000_000A, 4'b1111);
      wr(8'h28, 32'h0000_0001, 4'b0001);
      expect_out(SelHex + 0, 32'h08, "hex0_decoded_A");
      wr(8'h28, 32'h0000_0000, 4'b0001);
      expect_out(SelHex + 0, 32'h0A, "hex0_raw");
      wr(8'h24, 32'hFFFF_FFFF, 4'b1111);
      push_exp("hex4_raw", SelHex + 4, 32'h7F);
      push_exp("hex5_raw", SelHex + 5, 32'h7F);
      push_exp("hex6_absent", SelHex + 6, 32'h0);
      push_exp("hex7_absent", SelHex + 7, 32'h0);
      drain();
      expect_rd(8'h24, 32'h0000_7F7F, "hex_hi_rd");
      wr(8'h28, 32'h0000_00FF, 4'b0001);
      expect_rd(8'h28, 32'h0000_003F, "hex_mode_rd");
      push_exp("hex0_mode_all", SelHex + 0, 32'h08);
      push_exp("hex4_decoded_F", SelHex + 4, 32'h0E);
      push_exp("hex6_absent_mode", SelHex + 6, 32'h0);
      drain();

      // LCD with same-cycle load returning the old value
      addr   = 8'h30;
      w_data = 32'h1234_5678;
      bmask  = 4'b1010;
      wr_en  = 1'b1;
      push_exp("lcd_old_in_wr_cycle", SelRd, 32'h0);
      drain();
      @(negedge clk);
      wr_en = 1'b0;
      expect_rd(8'h30, 32'h1200_5600, "lcd_rd");
      expect_out(SelLcd, 32'h1200_5600, "io_lcd");

      // Unmapped addresses
      wr(8'h40, 32'hFFFF_FFFF, 4'b1111);
      expect_rd(8'h40, 32'h0, "unmapped_40");
      expect_rd(8'h2C, 32'h0, "unmapped_2c");
      expect_rd(8'h00, 32'h0000_004E, "ledr_after_unmapped");

      // Blink engine: half-period = DIV+1 cycles
      wr(8'h00, 32'h0000_00FF, 4'b1111);
      wr(8'h38, 32'h0000_000F, 4'b1111);
      expect_rd(8'h38, 32'h0000_000F, "blink_mask_rd");
      wr(8'h3C, 32'h0000_0003, 4'b1111);
      expect_rd(8'h3C, 32'h0000_0003, "blink_div_rd");
      expect_rd(8'h00, 32'h0000_00FF, "ledr_ungated_rd");
      for (int i = 0; i < 16; i++) begin
         expect_out(SelLedr, ((i / 4) % 2 == 0) ? 32'hFF : 32'hF0, $sformatf("blink_c%0d", i));
         @(negedge clk);
      end

      // Disable: steady, phase forced high
      wr(8'h3C, 32'h0, 4'b0001);
      for (int i = 0; i < 8; i++) begin
         expect_out(SelLedr, 32'hFF, $sformatf("blink_off_c%0d", i));
         @(negedge clk);
      end

      // Rewrite of BLINK_DIV on the terminal-count cycle reloads without toggling
      wr(8'h3C, 32'h0000_0003, 4'b0001);
      for (int i = 0; i < 3; i++) begin
         expect_out(SelLedr, 32'hFF, $sformatf("pre_reload_c%0d", i));
         @(negedge clk);
      end
      wr(8'h3C, 32'h0000_0003, 4'b0001);
      for (int i = 0; i < 8; i++) begin
         expect_out(SelLedr, (i < 4) ? 32'hFF : 32'hF0, $sformatf("reload_c%0d", i));
         @(negedge clk);
      end

      // Asynchronous reset mid-blink
      @(negedge clk);
      rst_n = 1'b0;
      check_all_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      expect_out(SelLedr, 32'h0, "post_reset_ledr");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
